// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants and types for the ID->EX operand fetch stage.
// Producer-select encoding is used by operand_resolve.
package operand_fetch_stage_pkg;

    localparam logic [3:0] REG_PC     = 4'd15;
    localparam logic [3:0] REG_LR     = 4'd14;
    localparam int         CTRL_W_DEF = 24;

    typedef enum logic [2:0] {
        SEL_RF,
        SEL_EX,
        SEL_MEM,
        SEL_WB,
        SEL_LINK,
        SEL_PC
    } sel_e;

    typedef struct packed {
        logic        ex_wr_en;
        logic        ex_is_load;
        logic [3:0]  ex_rd;
        logic [31:0] ex_result;
        logic        mem_wr_en;
        logic [3:0]  mem_rd;
        logic [31:0] mem_result;
        logic        wb_wr_en;
        logic [3:0]  wb_rd;
        logic [31:0] wb_result;
        logic        wb_link_en;
        logic [31:0] wb_link_val;
    } prod_t;

endpackage

// File: rtl/operand_resolve.sv
// Resolves one source operand against EX/MEM/WB producers.
// OPFETCH_FORWARD_EN selects forwarding; otherwise any pending write stalls.
module operand_resolve
    import operand_fetch_stage_pkg::*;
(
    input  logic        id_valid,
    input  logic        use_src,
    input  logic [3:0]  src,
    input  logic [31:0] rf_val,
    input  logic [31:0] pc8,
    input  prod_t       prod,
    output logic [31:0] val,
    output logic        hazard
);

    logic live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic link_hit;
    sel_e sel;

    assign live     = id_valid & use_src;
    assign ex_hit   = prod.ex_wr_en & (prod.ex_rd == src);
    assign mem_hit  = prod.mem_wr_en & (prod.mem_rd == src);
    assign wb_hit   = prod.wb_wr_en & (prod.wb_rd == src);
    assign link_hit = prod.wb_link_en & (src == REG_LR);

`ifdef OPFETCH_FORWARD_EN
    // Youngest producer wins; a load in EX has no data yet, so it stalls.
    always_comb begin
        sel    = SEL_RF;
        hazard = 1'b0;
        if (live) begin
            if (src == REG_PC) begin
                sel = SEL_PC;
            end else begin
                hazard = ex_hit & prod.ex_is_load;
                if (ex_hit & ~prod.ex_is_load) sel = SEL_EX;
                else if (mem_hit)              sel = SEL_MEM;
                else if (link_hit)             sel = SEL_LINK;
                else if (wb_hit)               sel = SEL_WB;
            end
        end
    end

    always_comb begin
        val = rf_val;
        case (sel)
            SEL_PC:   val = pc8;
            SEL_EX:   val = prod.ex_result;
            SEL_MEM:  val = prod.mem_result;
            SEL_LINK: val = prod.wb_link_val;
            SEL_WB:   val = prod.wb_result;
            default:  val = rf_val;
        endcase
    end
`else
    always_comb begin
        sel    = SEL_RF;
        hazard = 1'b0;
        if (live) begin
            if (src == REG_PC) sel = SEL_PC;
            else hazard = ex_hit | mem_hit | wb_hit | link_hit;
        end
    end

    assign val = (sel == SEL_PC) ? pc8 : rf_val;

    logic unused_prod;
    assign unused_prod = ^{prod.ex_is_load, prod.ex_result,
                           prod.mem_result, prod.wb_result,
                           prod.wb_link_val};
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// ID->EX boundary: operand hazard resolution, stall/flush, ID/EX register bank.
// Forwarding is enabled by defining OPFETCH_FORWARD_EN.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clock,
    input  logic              R,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [3:0]        id_rn,
    input  logic [3:0]        id_rm,
    input  logic [3:0]        id_rs,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic              id_use_c,
    input  logic [3:0]        id_rd,
    input  logic [31:0]       id_pc8,
    input  logic [31:0]       rf_a,
    input  logic [31:0]       rf_b,
    input  logic [31:0]       rf_c,
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [3:0]        ex_rd,
    input  logic [31:0]       ex_result,
    input  logic              mem_wr_en,
    input  logic [3:0]        mem_rd,
    input  logic [31:0]       mem_result,
    input  logic              wb_wr_en,
    input  logic [3:0]        wb_rd,
    input  logic [31:0]       wb_result,
    input  logic              wb_link_en,
    input  logic [31:0]       wb_link_val,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [31:0]       ex_op_a,
    output logic [31:0]       ex_op_b,
    output logic [31:0]       ex_op_c,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [3:0]        ex_rd_o
);

    prod_t       prod;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;
    logic        haz_a;
    logic        haz_b;
    logic        haz_c;
    logic        hazard;

    logic              valid_q, valid_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [31:0]       op_c_q, op_c_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [3:0]        rd_q, rd_d;

    always_comb begin
        prod.ex_wr_en    = ex_wr_en;
        prod.ex_is_load  = ex_is_load;
        prod.ex_rd       = ex_rd;
        prod.ex_result   = ex_result;
        prod.mem_wr_en   = mem_wr_en;
        prod.mem_rd      = mem_rd;
        prod.mem_result  = mem_result;
        prod.wb_wr_en    = wb_wr_en;
        prod.wb_rd       = wb_rd;
        prod.wb_result   = wb_result;
        prod.wb_link_en  = wb_link_en;
        prod.wb_link_val = wb_link_val;
    end

    operand_resolve u_res_a (
        .id_valid (id_valid),
        .use_src  (id_use_a),
        .src      (id_rn),
        .rf_val   (rf_a),
        .pc8      (id_pc8),
        .prod     (prod),
        .val      (op_a),
        .hazard   (haz_a)
    );

    operand_resolve u_res_b (
        .id_valid (id_valid),
        .use_src  (id_use_b),
        .src      (id_rm),
        .rf_val   (rf_b),
        .pc8      (id_pc8),
        .prod     (prod),
        .val      (op_b),
        .hazard   (haz_b)
    );

    operand_resolve u_res_c (
        .id_valid (id_valid),
        .use_src  (id_use_c),
        .src      (id_rs),
        .rf_val   (rf_c),
        .pc8      (id_pc8),
        .prod     (prod),
        .val      (op_c),
        .hazard   (haz_c)
    );

    assign hazard   = haz_a | haz_b | haz_c;
    // A taken branch kills the decode slot, so it never needs to hold.
    assign stall_id = hazard & ~flush & ~R;

    always_comb begin
        valid_d = valid_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_c_d  = op_c_q;
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        if (flush | hazard) begin
            valid_d = 1'b0;
        end else begin
            valid_d = id_valid;
            op_a_d  = op_a;
            op_b_d  = op_b;
            op_c_d  = op_c;
            ctrl_d  = id_ctrl;
            rd_d    = id_rd;
        end
    end

    always_ff @(posedge clock or posedge R) begin
        if (R) begin
            valid_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            op_c_q  <= '0;
            ctrl_q  <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            op_c_q  <= op_c_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
        end
    end

    assign ex_valid = valid_q;
    assign ex_op_a  = op_a_q;
    assign ex_op_b  = op_b_q;
    assign ex_op_c  = op_c_q;
    assign ex_ctrl  = ctrl_q;
    assign ex_rd_o  = rd_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: vector table, corner sequences, random vs model.
// Expectations follow OPFETCH_FORWARD_EN when it is defined.
module tb_operand_fetch_stage;

`ifdef OPFETCH_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        id_valid;
        logic [23:0] ctrl;
        logic [3:0]  rn, rm, rs;
        logic        ua, ub, uc;
        logic [3:0]  rd;
        logic [31:0] pc8, ra, rb, rc;
        logic        exw, exl;
        logic [3:0]  exd;
        logic [31:0] exr;
        logic        mw;
        logic [3:0]  md;
        logic [31:0] mr;
        logic        ww;
        logic [3:0]  wd;
        logic [31:0] wr;
        logic        le;
        logic [31:0] lv;
        logic        fl;
    } in_t;

    typedef struct {
        in_t         x;
        logic        e_stall;
        logic        e_valid;
        logic        cd;
        logic [31:0] ea, eb, ec;
    } tv_t;

    logic        clock = 1'b0;
    logic        R = 1'b1;
    logic        id_valid, id_use_a, id_use_b, id_use_c;
    logic [23:0] id_ctrl;
    logic [3:0]  id_rn, id_rm, id_rs, id_rd;
    logic [31:0] id_pc8, rf_a, rf_b, rf_c;
    logic        ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en, wb_link_en, flush;
    logic [3:0]  ex_rd, mem_rd, wb_rd;
    logic [31:0] ex_result, mem_result, wb_result, wb_link_val;
    logic        stall_id, ex_valid;
    logic [31:0] ex_op_a, ex_op_b, ex_op_c;
    logic [23:0] ex_ctrl;
    logic [3:0]  ex_rd_o;

    int n_pass = 0;
    int n_total = 0;
    logic s_stall;

    bit          m_valid, m_known;
    logic [31:0] m_a, m_b, m_c;
    logic [23:0] m_ctrl;
    logic [3:0]  m_rd;

    tv_t tv[11];

    always #5 clock = ~clock;

    operand_fetch_stage #(.CTRL_W(24)) dut (
        .clock(clock), .R(R),
        .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_c(id_use_c),
        .id_rd(id_rd), .id_pc8(id_pc8),
        .rf_a(rf_a), .rf_b(rf_b), .rf_c(rf_c),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result),
        .wb_link_en(wb_link_en), .wb_link_val(wb_link_val),
        .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_op_c(ex_op_c),
        .ex_ctrl(ex_ctrl), .ex_rd_o(ex_rd_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", nm, act, exp);
    endtask

    function automatic in_t idle();
        in_t r;
        r = '{default: '0};
        return r;
    endfunction

    function automatic in_t base();
        in_t r;
        r = idle();
        r.id_valid = 1'b1; r.ctrl = 24'h0000C1;
        r.rn = 4'd1; r.rm = 4'd2; r.rs = 4'd4;
        r.ua = 1'b1; r.ub = 1'b1; r.uc = 1'b1;
        r.rd = 4'd6; r.pc8 = 32'h208;
        r.ra = 32'h11; r.rb = 32'h22; r.rc = 32'h33;
        return r;
    endfunction

    task automatic drive(input in_t x);
        id_valid = x.id_valid; id_ctrl = x.ctrl;
        id_rn = x.rn; id_rm = x.rm; id_rs = x.rs;
        id_use_a = x.ua; id_use_b = x.ub; id_use_c = x.uc;
        id_rd = x.rd; id_pc8 = x.pc8;
        rf_a = x.ra; rf_b = x.rb; rf_c = x.rc;
        ex_wr_en = x.exw; ex_is_load = x.exl; ex_rd = x.exd; ex_result = x.exr;
        mem_wr_en = x.mw; mem_rd = x.md; mem_result = x.mr;
        wb_wr_en = x.ww; wb_rd = x.wd; wb_result = x.wr;
        wb_link_en = x.le; wb_link_val = x.lv; flush = x.fl;
    endtask

    // Reference: {hazard, value}, producers scanned youngest first.
    function automatic logic [32:0] ref_op(input in_t x, input logic u,
                                           input logic [3:0] s,
                                           input logic [31:0] rf);
        logic        en[4];
        logic [3:0]  dst[4];
        logic [31:0] pv[4];
        logic [31:0] v;
        logic        h, done;
        en[0] = x.exw; dst[0] = x.exd;  pv[0] = x.exr;
        en[1] = x.mw;  dst[1] = x.md;   pv[1] = x.mr;
        en[2] = x.le;  dst[2] = 4'd14;  pv[2] = x.lv;
        en[3] = x.ww;  dst[3] = x.wd;   pv[3] = x.wr;
        v = rf; h = 1'b0; done = 1'b0;
        if (x.id_valid && u && s == 4'd15) begin
            v = x.pc8;
        end else if (x.id_valid && u) begin
            for (int i = 0; i < 4; i++) begin
                if (en[i] && dst[i] == s) begin
                    if (!FWD) h = 1'b1;
                    else if (i == 0 && x.exl) h = 1'b1;
                    else if (!done) begin v = pv[i]; done = 1'b1; end
                end
            end
        end
        return {h, v};
    endfunction

    task automatic m_reset();
        m_valid = 1'b0; m_known = 1'b1;
        m_a = '0; m_b = '0; m_c = '0; m_ctrl = '0; m_rd = '0;
    endtask

    task automatic cycle(input in_t x);
        logic [32:0] pa, pb, pc;
        logic st;
        @(negedge clock);
        drive(x);
        pa = ref_op(x, x.ua, x.rn, x.ra);
        pb = ref_op(x, x.ub, x.rm, x.rb);
        pc = ref_op(x, x.uc, x.rs, x.rc);
        st = (pa[32] | pb[32] | pc[32]) & ~x.fl;
        #2;
        s_stall = stall_id;
        chk("m_stall", 32'(stall_id), 32'(st));
        @(posedge clock);
        if (x.fl) begin
            m_valid = 1'b0; m_known = 1'b0;
        end else if (st) begin
            m_valid = 1'b0;
        end else begin
            m_valid = x.id_valid;
            m_a = pa[31:0]; m_b = pb[31:0]; m_c = pc[31:0];
            m_ctrl = x.ctrl; m_rd = x.rd; m_known = 1'b1;
        end
        #1;
        chk("m_valid", 32'(ex_valid), 32'(m_valid));
        if (m_known) begin
            chk("m_op_a", ex_op_a, m_a);
            chk("m_op_b", ex_op_b, m_b);
            chk("m_op_c", ex_op_c, m_c);
            chk("m_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
            chk("m_rd", 32'(ex_rd_o), 32'(m_rd));
        end
    endtask

    task automatic set_tv(input int i, input in_t x, input logic st,
                          input logic vl, input logic cd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c);
        tv[i].x = x; tv[i].e_stall = st; tv[i].e_valid = vl;
        tv[i].cd = cd; tv[i].ea = a; tv[i].eb = b; tv[i].ec = c;
    endtask

    function automatic logic [3:0] rreg();
        logic [3:0] p[6];
        p = '{4'd3, 4'd5, 4'd7, 4'd14, 4'd15, 4'd1};
        return p[$urandom_range(0, 5)];
    endfunction

    function automatic in_t rnd();
        in_t r;
        r.id_valid = ($urandom_range(0, 7) != 0);
        r.ctrl = 24'($urandom);
        r.rn = rreg(); r.rm = rreg(); r.rs = rreg(); r.rd = rreg();
        r.ua = 1'($urandom_range(0, 1));
        r.ub = 1'($urandom_range(0, 1));
        r.uc = 1'($urandom_range(0, 1));
        r.pc8 = $urandom; r.ra = $urandom; r.rb = $urandom; r.rc = $urandom;
        r.exw = 1'($urandom_range(0, 1)); r.exl = 1'($urandom_range(0, 1));
        r.exd = rreg(); r.exr = $urandom;
        r.mw = 1'($urandom_range(0, 1)); r.md = rreg(); r.mr = $urandom;
        r.ww = 1'($urandom_range(0, 1)); r.wd = rreg(); r.wr = $urandom;
        r.le = 1'($urandom_range(0, 1)); r.lv = $urandom;
        r.fl = ($urandom_range(0, 7) == 0);
        return r;
    endfunction

    initial begin
        in_t x;
        int stalls, bubbles;

        // Table: each row is one decode cycle, applied in order.
        x = base();
        set_tv(0, x, 0, 1, 1, 32'h11, 32'h22, 32'h33);
        x = base(); x.rn = 4'd3;
        x.exw = 1; x.exd = 4'd3; x.exr = 32'hAAAA;
        x.mw = 1; x.md = 4'd3; x.mr = 32'hBBBB;
        if (FWD) set_tv(1, x, 0, 1, 1, 32'hAAAA, 32'h22, 32'h33);
        else     set_tv(1, x, 1, 0, 1, 32'h11, 32'h22, 32'h33);
        x = base(); x.rs = 4'd14;
        x.le = 1; x.lv = 32'h104; x.ww = 1; x.wd = 4'd14; x.wr = 32'h9;
        if (FWD) set_tv(2, x, 0, 1, 1, 32'h11, 32'h22, 32'h104);
        else     set_tv(2, x, 1, 0, 1, 32'h11, 32'h22, 32'h33);
        x = base(); x.rn = 4'd15;
        x.exw = 1; x.exd = 4'd15; x.exr = 32'hDEAD;
        set_tv(3, x, 0, 1, 1, 32'h208, 32'h22, 32'h33);
        x = base(); x.rm = 4'd5;
        x.exw = 1; x.exl = 1; x.exd = 4'd5; x.exr = 32'hDEAD;
        set_tv(4, x, 1, 0, 1, 32'h208, 32'h22, 32'h33);
        x = base(); x.rm = 4'd5; x.mw = 1; x.md = 4'd5; x.mr = 32'h55;
        if (FWD) set_tv(5, x, 0, 1, 1, 32'h11, 32'h55, 32'h33);
        else     set_tv(5, x, 1, 0, 1, 32'h208, 32'h22, 32'h33);
        x = tv[4].x; x.fl = 1;
        set_tv(6, x, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        x = base(); x.ub = 0; x.rm = 4'd3;
        x.exw = 1; x.exd = 4'd3; x.exr = 32'hAAAA;
        set_tv(7, x, 0, 1, 1, 32'h11, 32'h22, 32'h33);
        x = base(); x.id_valid = 0; x.rn = 4'd3;
        x.exw = 1; x.exl = 1; x.exd = 4'd3;
        set_tv(8, x, 0, 0, 1, 32'h11, 32'h22, 32'h33);
        x = base(); x.rn = 4'd7;
        x.ww = 1; x.wd = 4'd7; x.wr = 32'h77; x.mw = 1; x.md = 4'd8; x.mr = 32'h88;
        if (FWD) set_tv(9, x, 0, 1, 1, 32'h77, 32'h22, 32'h33);
        else     set_tv(9, x, 1, 0, 1, 32'h11, 32'h22, 32'h33);
        x = base(); x.rm = 4'd9;
        x.mw = 1; x.md = 4'd9; x.mr = 32'h99; x.ww = 1; x.wd = 4'd9; x.wr = 32'h90;
        if (FWD) set_tv(10, x, 0, 1, 1, 32'h11, 32'h99, 32'h33);
        else     set_tv(10, x, 1, 0, 1, 32'h11, 32'h22, 32'h33);

        // Reset with a load-use hazard present: stall must stay low.
        drive(tv[4].x);
        #12;
        chk("rst_stall", 32'(stall_id), 32'h0);
        chk("rst_valid", 32'(ex_valid), 32'h0);
        chk("rst_op_a", ex_op_a, 32'h0);
        chk("rst_op_b", ex_op_b, 32'h0);
        chk("rst_op_c", ex_op_c, 32'h0);
        chk("rst_ctrl", 32'(ex_ctrl), 32'h0);
        chk("rst_rd", 32'(ex_rd_o), 32'h0);
        @(negedge clock);
        drive(idle());
        R = 1'b0;
        m_reset();

        for (int i = 0; i < 11; i++) begin
            cycle(tv[i].x);
            chk($sformatf("tv%0d_stall", i), 32'(s_stall), 32'(tv[i].e_stall));
            chk($sformatf("tv%0d_valid", i), 32'(ex_valid), 32'(tv[i].e_valid));
            if (tv[i].cd) begin
                chk($sformatf("tv%0d_op_a", i), ex_op_a, tv[i].ea);
                chk($sformatf("tv%0d_op_b", i), ex_op_b, tv[i].eb);
                chk($sformatf("tv%0d_op_c", i), ex_op_c, tv[i].ec);
            end
        end

        // Producer of r3 walks EX -> MEM -> WB -> register file.
        stalls = 0; bubbles = 0;
        for (int c = 0; c < 4; c++) begin
            x = base(); x.rn = 4'd3;
            case (c)
                0: begin x.exw = 1; x.exd = 4'd3; x.exr = 32'hE3; end
                1: begin x.mw = 1; x.md = 4'd3; x.mr = 32'hE3; end
                2: begin x.ww = 1; x.wd = 4'd3; x.wr = 32'hE3; end
                default: x.ra = 32'hE3;
            endcase
            cycle(x);
            if (s_stall) stalls++;
            if (!ex_valid) bubbles++;
        end
        chk("raw_stalls", 32'(stalls), FWD ? 32'd0 : 32'd3);
        chk("raw_bubbles", 32'(bubbles), FWD ? 32'd0 : 32'd3);
        chk("raw_op_a", ex_op_a, 32'hE3);
        chk("raw_valid", 32'(ex_valid), 32'h1);

        // Asynchronous reset in the middle of a load-use stall.
        @(negedge clock);
        drive(tv[4].x);
        #2;
        chk("mid_stall_pre", 32'(stall_id), 32'h1);
        R = 1'b1;
        #1;
        chk("mid_stall", 32'(stall_id), 32'h0);
        chk("mid_valid", 32'(ex_valid), 32'h0);
        chk("mid_op_a", ex_op_a, 32'h0);
        chk("mid_op_b", ex_op_b, 32'h0);
        chk("mid_op_c", ex_op_c, 32'h0);
        chk("mid_ctrl", 32'(ex_ctrl), 32'h0);
        @(negedge clock);
        drive(idle());
        R = 1'b0;
        m_reset();
        cycle(base());
        chk("post_rst_op_a", ex_op_a, 32'h11);
        chk("post_rst_valid", 32'(ex_valid), 32'h1);

        for (int i = 0; i < 400; i++) cycle(rnd());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
